instr_prefetch_queue: RTL and testbench



---
 rtl/ifq_pkg.sv | 19 +
 rtl/instr_prefetch_queue_if.sv | 28 ++
 rtl/ifq_fifo.sv | 47 ++++
 rtl/instr_prefetch_queue.sv | 103 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// Shared types for the instruction prefetch queue: widths, fetch FSM states
// and the buffered {pc, instr} entry.
package ifq_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } ifq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory port, decode-side pop handshake and redirect bundle.
// master = the prefetch queue, slave = memory/decode/execute environment.
interface instr_prefetch_queue_if;
  import ifq_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_addr, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_addr, out_ready
  );

endinterface

// File: rtl/ifq_fifo.sv
// Register FIFO of {pc, instr} entries; clear beats push and pop, head is read
// combinationally at the read pointer.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  ifq_entry_t    push_data,
  input  logic          pop,
  output ifq_entry_t    head,
  output logic [CW-1:0] count
);

  ifq_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // NOTE: storage is reset because the head feeds the outputs directly and must read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with one outstanding request and redirect flush.
// Optional macro IFQ_MISALIGN_CHECK_EN adds misalign_err and stalls fetch on a misaligned target.
module instr_prefetch_queue
  import ifq_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  instr_prefetch_queue_if.master  bus
`ifdef IFQ_MISALIGN_CHECK_EN
  ,
  output logic                    misalign_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e      state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   count;
  logic            accept;
  logic            push;
  logic            pop;
  logic            req_block;
  ifq_entry_t      push_data;
  ifq_entry_t      head;

  assign redirect_target = bus.redirect_addr & ~XLEN'(3);

`ifdef IFQ_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             misalign_err <= 1'b0;
    else if (bus.redirect) misalign_err <= |bus.redirect_addr[1:0];
  end
  assign req_block = misalign_err;
`else
  assign req_block = 1'b0;
`endif

  // Reset gates the request so it is low while held in reset and high on release.
  assign bus.imem_req  = !reset && (state == IDLE) && (count < CW'(DEPTH)) && !req_block;
  assign bus.imem_addr = fetch_pc;
  assign accept        = bus.imem_req && bus.imem_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign push_data     = '{pc: req_pc, instr: bus.imem_rdata};

  // NOTE: defaults first so every path assigns state_next and push, avoiding latches.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (bus.imem_rvalid) begin
                 push       = !bus.redirect;
                 state_next = IDLE;
               end
      DISCARD: if (bus.imem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.redirect) begin
      case (state)
        IDLE:    state_next = accept ? DISCARD : IDLE;
        WAIT:    state_next = bus.imem_rvalid ? IDLE : DISCARD;
        // The orphan response still retires the outstanding request here.
        DISCARD: state_next = bus.imem_rvalid ? IDLE : DISCARD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state <= state_next;
      if (bus.redirect)  fetch_pc <= redirect_target;
      else if (accept)   fetch_pc <= fetch_pc + XLEN'(4);
      if (accept) req_pc <= fetch_pc;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: streaming, back-pressure, redirect
// corner cases, reset mid-fetch and target alignment (IFQ_MISALIGN_CHECK_EN).
module tb_instr_prefetch_queue;
  import ifq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_prefetch_queue_if bus ();
`ifdef IFQ_MISALIGN_CHECK_EN
  logic misalign_err;
`endif

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic       auto_resp = 1'b1;
  logic       held_valid = 1'b0;
  logic [63:0] held_addr = '0;
  ifq_entry_t popped[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC3A5_0000;
  endfunction

  // One clock: sample accept/pop at the negedge, then model memory after the edge.
  task automatic step();
    logic        acc;
    logic [63:0] acc_addr;
    ifq_entry_t  e;
    @(negedge clk);
    acc      = bus.imem_req && bus.imem_ready;
    acc_addr = bus.imem_addr;
    if (bus.out_valid && bus.out_ready && !bus.redirect && !reset) begin
      e.pc    = bus.out_pc;
      e.instr = bus.out_instr;
      popped.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    if (acc) begin
      if (auto_resp) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr_of(acc_addr);
      end else begin
        held_valid = 1'b1;
        held_addr  = acc_addr;
      end
    end
  endtask

  task automatic do_redirect(input logic [63:0] target);
    bus.redirect      = 1'b1;
    bus.redirect_addr = target;
    step();
    bus.redirect      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ready    = 1'b1;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = '0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.out_ready     = 1'b1;

    // Reset held and released
    #2;
    check("rst_req_held", bus.imem_req, 0);
    check("rst_valid", bus.out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rel_req", bus.imem_req, 1);
    check("rel_addr", bus.imem_addr, 64'h1000);
    check("rel_valid", bus.out_valid, 0);
    check("rel_pc", bus.out_pc, 0);
    check("rel_instr", bus.out_instr, 0);

    // Streaming: one instruction every two cycles
    for (int k = 0; k < 3; k++) begin
      step();
      check("stream_gap", bus.out_valid, 0);
      step();
      check("stream_valid", bus.out_valid, 1);
      check("stream_pc", bus.out_pc, 64'h1000 + 64'(4 * k));
      check("stream_instr", bus.out_instr, instr_of(64'h1000 + 64'(4 * k)));
    end

    // Back-pressure: queue fills and requests stop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("full_req", bus.imem_req, 0);
    check("full_valid", bus.out_valid, 1);
    check("full_head", bus.out_pc, 64'h1008);
    popped.delete();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("pop1_req", bus.imem_req, 1);
    check("pop1_addr", bus.imem_addr, 64'h1018);
    check("pop1_head", bus.out_pc, 64'h100C);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("drain_count", 64'(popped.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) begin
        check("drain_pc", popped[i].pc, 64'h1008 + 64'(4 * i));
        check("drain_instr", popped[i].instr, instr_of(64'h1008 + 64'(4 * i)));
      end

    // Redirect in WAIT, stale response three cycles later
    auto_resp = 1'b0;
    for (int i = 0; i < 10 && !held_valid; i++) step();
    check("t3_held", held_valid, 1);
    popped.delete();
    do_redirect(64'h2000);
    check("t3_discard_req", bus.imem_req, 0);
    check("t3_flushed", bus.out_valid, 0);
    auto_resp = 1'b1;
    step();
    step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = instr_of(held_addr);
    held_valid      = 1'b0;
    step();
    check("t3_stale_dropped", bus.out_valid, 0);
    check("t3_req", bus.imem_req, 1);
    check("t3_addr", bus.imem_addr, 64'h2000);
    step();
    step();
    check("t3_valid", bus.out_valid, 1);
    check("t3_pc", bus.out_pc, 64'h2000);
    check("t3_instr", bus.out_instr, instr_of(64'h2000));
    step();
    check("t3_first_pop", 64'(popped.size() >= 1), 1);
    if (popped.size() >= 1) check("t3_first_pc", popped[0].pc, 64'h2000);

    // Redirect coincident with rvalid
    for (int i = 0; i < 10 && !bus.imem_rvalid; i++) step();
    check("t4a_sync", bus.imem_rvalid, 1);
    do_redirect(64'h3000);
    check("t4a_dropped", bus.out_valid, 0);
    check("t4a_req", bus.imem_req, 1);
    check("t4a_addr", bus.imem_addr, 64'h3000);
    step();
    step();
    check("t4a_pc", bus.out_pc, 64'h3000);
    check("t4a_instr", bus.out_instr, instr_of(64'h3000));

    // Redirect coincident with accept
    for (int i = 0; i < 10 && !bus.imem_req; i++) step();
    check("t4b_sync", bus.imem_req, 1);
    do_redirect(64'h4000);
    check("t4b_discard_req", bus.imem_req, 0);
    check("t4b_flushed", bus.out_valid, 0);
    step();
    check("t4b_dropped", bus.out_valid, 0);
    check("t4b_req", bus.imem_req, 1);
    check("t4b_addr", bus.imem_addr, 64'h4000);
    step();
    step();
    check("t4b_pc", bus.out_pc, 64'h4000);
    check("t4b_instr", bus.out_instr, instr_of(64'h4000));

    // Reset during WAIT, stale response after release
    auto_resp = 1'b0;
    for (int i = 0; i < 10 && !held_valid; i++) step();
    check("t5_held", held_valid, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_req", bus.imem_req, 0);
    check("t5_rst_valid", bus.out_valid, 0);
    step();
    reset = 1'b0;
    #1;
    check("t5_rel_req", bus.imem_req, 1);
    check("t5_rel_addr", bus.imem_addr, 64'h1000);
    auto_resp       = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = instr_of(held_addr);
    held_valid      = 1'b0;
    step();
    check("t5_stale_ignored", bus.out_valid, 0);
    step();
    check("t5_valid", bus.out_valid, 1);
    check("t5_pc", bus.out_pc, 64'h1000);
    check("t5_instr", bus.out_instr, instr_of(64'h1000));

    // Misaligned redirect target
    for (int i = 0; i < 10 && !bus.imem_req; i++) step();
`ifdef IFQ_MISALIGN_CHECK_EN
    do_redirect(64'h2002);
    check("mis_err_set", misalign_err, 1);
    check("mis_req_off", bus.imem_req, 0);
    for (int i = 0; i < 3; i++) step();
    check("mis_err_hold", misalign_err, 1);
    check("mis_req_hold", bus.imem_req, 0);
    do_redirect(64'h3000);
    check("mis_err_clr", misalign_err, 0);
    check("mis_req_on", bus.imem_req, 1);
    check("mis_addr", bus.imem_addr, 64'h3000);
    step();
    step();
    check("mis_pc", bus.out_pc, 64'h3000);
`else
    do_redirect(64'h5003);
    step();
    check("align_req", bus.imem_req, 1);
    check("align_addr", bus.imem_addr, 64'h5000);
    step();
    step();
    check("align_pc", bus.out_pc, 64'h5000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
